// File: rtl/ram_rw_pkg.sv
// Shared types and helpers for the RAM read/write test controller.
package ram_rw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int ERR_CNT_W = 8;

    // Test pattern: each word holds its own address plus one.
    function automatic logic [31:0] expected(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/ram_rw_ctrl_rd_lat_pipe.sv
// RD_LAT-stage delay line of {valid, addr} that tracks reads in flight to the RAM.
module rd_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [RD_LAT-1:0]             valid_d;
    logic [RD_LAT-1:0]             valid_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_q;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = in_valid;
                assign addr_d[gi]  = in_addr;
            end else begin : g_body
                assign valid_d[gi] = valid_q[gi-1];
                assign addr_d[gi]  = addr_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_rw_ctrl.sv
// Write-then-readback test controller for a single-port RAM.
// Define RAM_RW_LOOP_EN to let a held start chain passes directly from DONE to WRITE.
module ram_rw_ctrl
    import ram_rw_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_e                 state_q,     state_d;
    logic                   ram_en_q,    ram_en_d;
    logic                   ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0]      ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   err_q,       err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [ADDR_W-1:0]      err_addr_q,  err_addr_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;

    logic                   pipe_valid;
    logic [ADDR_W-1:0]      pipe_addr;
    logic [ADDR_W-1:0]      next_addr;
    logic [DATA_W-1:0]      pipe_exp;

    assign next_addr = ram_addr_q + 1'b1;
    assign pipe_exp  = DATA_W'(expected(32'(pipe_addr)));

    rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_rd_lat_pipe (
        .clk       (sys_clk),
        .srst      (sys_rst),
        .in_valid  (state_q == ST_READ),
        .in_addr   (ram_addr_q),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr)
    );

    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        drain_cnt_d = drain_cnt_q;

        // Readback compare; only the first mismatch of a test records its address.
        if (pipe_valid && (ram_rdata != pipe_exp)) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!err_q) begin
                err_addr_d = pipe_addr;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = '0;
                    ram_wdata_d = DATA_W'(expected(32'd0));
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    err_cnt_d   = '0;
                    err_addr_d  = '0;
                end
            end
            ST_WRITE: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d     = ST_READ;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = '0;
                    ram_wdata_d = '0;
                end else begin
                    ram_addr_d  = next_addr;
                    ram_wdata_d = DATA_W'(expected(32'(next_addr)));
                end
            end
            ST_READ: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d     = ST_DRAIN;
                    ram_en_d    = 1'b0;
                    ram_addr_d  = '0;
                    drain_cnt_d = '0;
                end else begin
                    ram_addr_d = next_addr;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
`ifdef RAM_RW_LOOP_EN
                // Chained pass: error state keeps accumulating across passes.
                if (start) begin
                    state_d     = ST_WRITE;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = '0;
                    ram_wdata_d = DATA_W'(expected(32'd0));
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;

endmodule
